// File: rtl/ghash_controller_pkg.sv
// Shared GCM definitions: field width, GHASH sequencer states and the GF(2^128) product
// using the bit-reflected GCM convention with reduction constant R = 0xe1 << 120.
package ghash_controller_pkg;

  localparam int DATA_WIDTH = 128;
  localparam logic [127:0] GF_R = 128'he1 << 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AAD,
    ST_CT,
    ST_LEN,
    ST_MUL,
    ST_DONE
  } ghash_state_t;

  // Right-shift multiply: bit 127 of x is the x^0 coefficient.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

endpackage

// File: rtl/ghash_controller_multiplier.sv
// Combinational GF(2^128) multiplier; x_o = a_i * h_i, compute_hh_o = h_i * h_i.
// Meant to be timed as a multicycle path by the controller that owns it.
module multiplier
  import ghash_controller_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] h_i,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [DATA_WIDTH-1:0] compute_hh_o
);

  assign x_o          = gf_mul(a_i, h_i);
  assign compute_hh_o = gf_mul(h_i, h_i);

endmodule

// File: rtl/ghash_controller.sv
// GHASH sequencer: Y <= (Y ^ X) * H over AAD blocks, CT blocks, then the length block.
// One block per MULT_STAGES+1 cycles; tag_o/tag_valid_o held until tag_ready_i.
module ghash_controller
  import ghash_controller_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int MULT_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic [63:0]           len_aad_i,
  input  logic [63:0]           len_ct_i,
  input  logic [DATA_WIDTH-1:0] blk_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] tag_o,
  output logic                  tag_valid_o,
  input  logic                  tag_ready_i
);

  localparam int CW = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MULT_STAGES - 1);

  ghash_state_t r_state, r_ret;
  ghash_state_t w_state_nxt, w_ret_nxt;

  logic [DATA_WIDTH-1:0] r_y, r_op, r_h;
  logic [63:0]           r_len_aad, r_len_ct;
  logic [56:0]           r_n_aad, r_n_ct;
  logic [CW-1:0]         r_cnt;

  logic [DATA_WIDTH-1:0] w_x, w_hh_unused;
  logic [56:0]           w_n_aad_init, w_n_ct_init;

  // Block counts round up so a partial final block still takes one slot.
  assign w_n_aad_init = len_aad_i[63:7] + {56'd0, |len_aad_i[6:0]};
  assign w_n_ct_init  = len_ct_i[63:7]  + {56'd0, |len_ct_i[6:0]};

  multiplier u_mult (
    .a_i          (r_op),
    .h_i          (r_h),
    .x_o          (w_x),
    .compute_hh_o (w_hh_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ret   <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (w_n_aad_init != 57'd0)     w_state_nxt = ST_AAD;
          else if (w_n_ct_init != 57'd0) w_state_nxt = ST_CT;
          else                           w_state_nxt = ST_LEN;
        end
      end
      ST_AAD: begin
        if (blk_valid_i) begin
          w_state_nxt = ST_MUL;
          if (r_n_aad != 57'd1)     w_ret_nxt = ST_AAD;
          else if (r_n_ct != 57'd0) w_ret_nxt = ST_CT;
          else                      w_ret_nxt = ST_LEN;
        end
      end
      ST_CT: begin
        if (blk_valid_i) begin
          w_state_nxt = ST_MUL;
          w_ret_nxt   = (r_n_ct != 57'd1) ? ST_CT : ST_LEN;
        end
      end
      ST_LEN: begin
        w_state_nxt = ST_MUL;
        w_ret_nxt   = ST_DONE;
      end
      ST_MUL: begin
        if (r_cnt == '0) w_state_nxt = r_ret;
      end
      ST_DONE: begin
        if (tag_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y       <= '0;
      r_op      <= '0;
      r_h       <= '0;
      r_len_aad <= '0;
      r_len_ct  <= '0;
      r_n_aad   <= '0;
      r_n_ct    <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_h       <= h_i;
            r_len_aad <= len_aad_i;
            r_len_ct  <= len_ct_i;
            r_n_aad   <= w_n_aad_init;
            r_n_ct    <= w_n_ct_init;
            r_y       <= '0;
          end
        end
        ST_AAD: begin
          if (blk_valid_i) begin
            r_op    <= r_y ^ blk_i;
            r_n_aad <= r_n_aad - 57'd1;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_CT: begin
          if (blk_valid_i) begin
            r_op   <= r_y ^ blk_i;
            r_n_ct <= r_n_ct - 57'd1;
            r_cnt  <= CNT_INIT;
          end
        end
        ST_LEN: begin
          r_op  <= r_y ^ {r_len_aad, r_len_ct};
          r_cnt <= CNT_INIT;
        end
        ST_MUL: begin
          // Operand and H stay stable while the product settles over r_cnt cycles.
          if (r_cnt == '0) r_y <= w_x;
          else             r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign blk_ready_o = (r_state == ST_AAD) || (r_state == ST_CT);
  assign busy_o      = (r_state != ST_IDLE);
  assign tag_valid_o = (r_state == ST_DONE);
  assign tag_o       = (r_state == ST_DONE) ? r_y : '0;

endmodule
